arb_burst_xfer: RTL and testbench
=================================

# arb_burst_xfer

Downstream consumer of the 4-way round-robin arbiter's registered one-hot grant. Each grant pulse opens a fixed-length burst from the granted requester's data lane onto a single shared valid/ready output channel. The block returns per-lane ready and a completion pulse to the requesters, and emits a request-gate so that no new grant issues while a burst is open.

## Interface
- `DW`, 32, data width per lane and on the output.
- `BURST_LEN`, 4, beats per grant; legal range 1..256.
- `CW`, `$clog2(BURST_LEN)` (minimum 1), beat counter width; derived, not overridden.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `grant`  in  4  one-hot grant pulse from the arbiter; at most one cycle high per burst.
- `lane_valid`  in  4  per-lane beat valid.
- `lane_data`  in  4*DW  lane i occupies bits `[i*DW +: DW]`.
- `lane_ready`  out  4  per-lane beat accepted; only the owning lane can be high.
- `req_gate`  out  1  `= ~busy & ~|grant`; upstream ANDs this into the arbiter `req`.
- `out_valid`  out  1  output beat valid.
- `out_data`  out  DW  output beat data.
- `out_src`  out  2  index of the owning lane.
- `out_last`  out  1  final beat of the burst.
- `out_ready`  in  1  downstream accept.
- `done`  out  4  one-cycle pulse on the owning lane after its last beat is accepted.
- `err`  out  1  sticky protocol error; present only under the config macro, otherwise tied 0.

## Operation
- States: `IDLE`, `XFER`. `busy = (state == XFER)`.
- In `IDLE`, a nonzero `grant` latches the encoded `src`, clears `cnt`, and moves to `XFER` on the next edge.
- With no error checking, a multi-hot `grant` resolves to its lowest set bit.
- In `XFER`:
  - `out_valid = lane_valid[src]`
  - `out_data = lane_data[src]`
  - `out_src = src`
  - `out_last = (cnt == BURST_LEN-1)`
  - `lane_ready[src] = out_ready`; all other lanes read 0.
- A beat is a handshake: `out_valid & out_ready`. Each handshake increments `cnt`.
- A handshake with `out_last` set drives `done[src]` for one cycle on the following cycle, clears `cnt`, and returns to `IDLE`.
- `out_valid` may drop mid-burst (lane bubble). The burst holds ownership indefinitely and has no timeout.
- `out_data` and `out_src` must be stable while `out_valid & ~out_ready`, provided the lane holds its data. The block adds no storage.
- `grant` arriving in `XFER` is ignored; the burst is unaffected.
- `BURST_LEN == 1`: `out_last` is high on every beat.
- Reset, asynchronous and valid at any point including mid-burst:
  - state `IDLE`, `src` 0, `cnt` 0, `done` 0, `err` 0
  - `out_valid`, `lane_ready`, `out_last` read 0
  - `req_gate` reads 1 if `grant` is 0
  - a partially sent burst is abandoned with no `done`.

## Timing
- `grant` high in cycle t → `XFER` from t+1; earliest first beat at t+1.
- `req_gate` is low in cycle t, because `grant` is nonzero, and stays low through the burst. The arbiter therefore issues no grant at t+1 or after while busy.
- Last handshake in cycle u → `IDLE` and `done` pulse at u+1; `req_gate` high at u+1.
- Next arbiter grant earliest at u+2; next first beat earliest at u+3.
- Minimum burst duration `BURST_LEN` cycles; back-to-back grant-to-grant spacing is `BURST_LEN + 2` cycles.
- All outputs except `done` and `err` are combinational from state and inputs. `done` and `err` are registered.

## Configuration
- Macro: `ARB_BURST_XFER_ERRCHK_EN`.
- Defined:
  - `err` sets on a non-one-hot nonzero `grant` in `IDLE`; that grant is dropped and the block stays `IDLE`.
  - `err` sets on any nonzero `grant` in `XFER`, which is ignored.
  - `err` clears only on reset.
- Undefined: no checking logic. `err` is tied 0, and the lowest-bit resolution rule applies.

## Test plan
- Reset release, `grant=4'b0100`, `lane_valid[2]=1`, `out_ready=1`, `BURST_LEN=4` → beats with `out_src=2` in cycles t+1..t+4, `out_last` only at t+4, `done=4'b0100` at t+5, `req_gate` 0 during t..t+4 and 1 at t+5.
- Same burst with `out_ready` low for 3 cycles after beat 1 → `out_data` held; `cnt` does not advance; `out_last` on the 4th accepted beat only; total 7 beats of wall time.
- `lane_valid[1]` toggles 1,0,1,0... during a `grant=4'b0010` burst → exactly 4 handshakes; `lane_ready[0,2,3]` stay 0 throughout.
- Arbiter plus block with all 4 `req` held high → grants in order lane 0,1,2,3,0, spaced `BURST_LEN+2` cycles apart; no grant while busy.
- Reset asserted after beat 2 of a burst → immediate `IDLE`, `out_valid=0`, no `done`; the next grant starts a fresh 4-beat burst.
- With `ARB_BURST_XFER_ERRCHK_EN`: `grant=4'b0011` in `IDLE` → no burst, `err=1` next cycle. Without the macro: the same grant gives a burst on lane 0 and `err=0`.

Source files
------------

// File: rtl/arb_burst_xfer_if.sv
// rtl/arb_burst_xfer_if.sv - grant, lane and output channel bundle for arb_burst_xfer
// master drives grant, lanes and out_ready; slave is the burst block.
interface arb_burst_xfer_if #(
  parameter int DW = 32
);
  logic [3:0]      grant;
  logic [3:0]      lane_valid;
  logic [4*DW-1:0] lane_data;
  logic [3:0]      lane_ready;
  logic            req_gate;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;
  logic            out_last;
  logic            out_ready;
  logic [3:0]      done;
  logic            err;

  modport master (
    output grant, lane_valid, lane_data, out_ready,
    input  lane_ready, req_gate, out_valid, out_data, out_src, out_last, done, err
  );

  modport slave (
    input  grant, lane_valid, lane_data, out_ready,
    output lane_ready, req_gate, out_valid, out_data, out_src, out_last, done, err
  );
endinterface

// File: rtl/arb_burst_xfer.sv
// rtl/arb_burst_xfer.sv - fixed-length burst mux driven by a one-hot arbiter grant
// Optional grant protocol checking under ARB_BURST_XFER_ERRCHK_EN.
module arb_burst_xfer #(
  parameter int DW        = 32,
  parameter int BURST_LEN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  arb_burst_xfer_if.slave bus
);
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_src, w_src_nxt, w_grant_idx;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_done, w_done_nxt;
  logic          w_busy, w_last, w_hs, w_grant_take;
  logic [DW-1:0] w_lane_data [4];

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign w_lane_data[g] = bus.lane_data[g*DW +: DW];
  end

  // Lowest set bit wins on a multi-hot grant.
  always_comb begin
    w_grant_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.grant[i]) w_grant_idx = 2'(i);
    end
  end

  assign w_busy = (r_state == XFER);
  assign w_last = (r_cnt == LAST_CNT);
  assign w_hs   = w_busy & bus.lane_valid[r_src] & bus.out_ready;

  assign bus.out_valid  = w_busy & bus.lane_valid[r_src];
  assign bus.out_data   = w_busy ? w_lane_data[r_src] : '0;
  assign bus.out_src    = r_src;
  assign bus.out_last   = w_busy & w_last;
  assign bus.lane_ready = w_busy ? ({3'b000, bus.out_ready} << r_src) : 4'b0000;
  assign bus.req_gate   = ~w_busy & ~(|bus.grant);
  assign bus.done       = r_done;

`ifdef ARB_BURST_XFER_ERRCHK_EN
  logic r_err;
  logic w_onehot;

  assign w_onehot     = ((bus.grant & (bus.grant - 4'd1)) == 4'd0);
  assign w_grant_take = (|bus.grant) & w_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((|bus.grant) & (w_busy | ~w_onehot)) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign w_grant_take = |bus.grant;
  assign bus.err      = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_src;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 4'b0000;
    unique case (r_state)
      IDLE: begin
        if (w_grant_take) begin
          w_state_nxt = XFER;
          w_src_nxt   = w_grant_idx;
          w_cnt_nxt   = '0;
        end
      end
      XFER: begin
        if (w_hs) begin
          if (w_last) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_done_nxt  = 4'b0001 << r_src;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_src   <= 2'd0;
      r_cnt   <= '0;
      r_done  <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      r_src   <= w_src_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end
endmodule

// File: tb/tb_arb_burst_xfer.sv
// tb/tb_arb_burst_xfer.sv - scoreboard bench for arb_burst_xfer
// Lane requesters and a round-robin arbiter are modelled here around the DUT.
`timescale 1ns/1ps
module tb_arb_burst_xfer;
  localparam int DW = 32;
  localparam int BL = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    src;
    logic          last;
    int            cyc;
  } beat_t;

  typedef struct {
    logic [3:0] d;
    int         cyc;
  } done_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  beat_t exp_q[$];
  done_t done_q[$];
  beat_t mb;
  done_t md;
  int    lane_beat[4] = '{default: 0};
  int    exp_beat[4] = '{default: 0};

  logic [3:0] stim_grant = 4'b0000;
  logic [3:0] arb_req = 4'b0000;
  logic       arb_en = 1'b0;
  logic [3:0] arb_grant;
  logic [1:0] arb_last;
  logic [3:0] arb_req_eff;
  logic [1:0] arb_pick;

  arb_burst_xfer_if #(.DW(DW)) bus ();

  arb_burst_xfer #(.DW(DW), .BURST_LEN(BL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input int l, input int n);
    return 32'hA000_0000 | (32'(l) << 24) | 32'(n & 32'hFFFF);
  endfunction

  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = 2'(last + 2'(k));
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input int lane, input int cv[BL], input int dcyc, input logic with_done);
    beat_t b;
    done_t d;
    for (int k = 0; k < BL; k++) begin
      b.data = mk(lane, exp_beat[lane]);
      exp_beat[lane]++;
      b.src  = 2'(lane);
      b.last = (k == BL - 1);
      b.cyc  = cv[k];
      exp_q.push_back(b);
    end
    if (with_done) begin
      d.d   = 4'b0001 << lane;
      d.cyc = dcyc;
      done_q.push_back(d);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && (exp_q.size() != 0 || done_q.size() != 0); i++) tick();
    chk(name, 64'(exp_q.size() + done_q.size()), 64'd0);
  endtask

  // Requester lanes: each lane presents a sequence number that advances on its own handshake.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign bus.lane_data[g*DW +: DW] = mk(g, lane_beat[g]);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (bus.lane_ready[i] && bus.lane_valid[i]) lane_beat[i] <= lane_beat[i] + 1;
    end
  end

  assign arb_req_eff = arb_req & {4{bus.req_gate}};
  assign arb_pick    = rr_pick(arb_req_eff, arb_last);
  assign bus.grant   = arb_en ? arb_grant : stim_grant;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_grant <= 4'b0000;
      arb_last  <= 2'd3;
    end else begin
      arb_grant <= 4'b0000;
      if (arb_en && (|arb_req_eff)) begin
        arb_grant <= 4'b0001 << arb_pick;
        arb_last  <= arb_pick;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected act=%0h exp=none", bus.out_data);
        end else begin
          mb = exp_q.pop_front();
          chk("beat_data", 64'(bus.out_data), 64'(mb.data));
          chk("beat_src", 64'(bus.out_src), 64'(mb.src));
          chk("beat_last", 64'(bus.out_last), 64'(mb.last));
          if (mb.cyc >= 0) chk("beat_cyc", 64'(cyc), 64'(mb.cyc));
        end
      end
      if (bus.done != 4'b0000) begin
        if (done_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected act=%0h exp=none", bus.done);
        end else begin
          md = done_q.pop_front();
          chk("done_val", 64'(bus.done), 64'(md.d));
          if (md.cyc >= 0) chk("done_cyc", 64'(cyc), 64'(md.cyc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int t;
    int cv[BL];
    int n;
    int gcyc[5];
    logic [3:0] glane[5];
    logic [3:0] gexp[5];
    logic [DW-1:0] hd;
    int b0;

    bus.lane_valid = 4'b0000;
    bus.out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_lane_ready", 64'(bus.lane_ready), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_req_gate", 64'(bus.req_gate), 64'd1);
    rst_n = 1'b1;
    tick();

    // Full-rate burst on lane 2
    bus.lane_valid = 4'b0100;
    bus.out_ready  = 1'b1;
    t = cyc;
    cv = '{t+1, t+2, t+3, t+4};
    push_burst(2, cv, t + 5, 1'b1);
    stim_grant = 4'b0100;
    #1 chk("t1_gate_grant", 64'(bus.req_gate), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      stim_grant = 4'b0000;
      #1 chk("t1_gate_busy", 64'(bus.req_gate), 64'd0);
    end
    tick();
    chk("t1_gate_after", 64'(bus.req_gate), 64'd1);
    chk("t1_idle_valid", 64'(bus.out_valid), 64'd0);
    drain("t1_drain");

    // Backpressure after the first beat
    t = cyc;
    cv = '{t+1, t+5, t+6, t+7};
    push_burst(2, cv, t + 8, 1'b1);
    stim_grant = 4'b0100;
    tick();
    stim_grant = 4'b0000;
    tick();
    hd = mk(2, exp_beat[2] - 3);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("t2_hold_data", 64'(bus.out_data), 64'(hd));
      chk("t2_hold_last", 64'(bus.out_last), 64'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    drain("t2_drain");

    // Lane bubbles on lane 1; other lanes stay valid but must never see ready
    bus.lane_valid = 4'b1101;
    b0 = lane_beat[1];
    t = cyc;
    cv = '{t+1, t+3, t+5, t+7};
    push_burst(1, cv, t + 8, 1'b1);
    stim_grant = 4'b0010;
    for (int c = 1; c <= 7; c++) begin
      tick();
      stim_grant = 4'b0000;
      bus.lane_valid[1] = c[0];
      #1 chk("t3_lane_ready", 64'(bus.lane_ready), 64'b0010);
    end
    tick();
    bus.lane_valid[1] = 1'b0;
    drain("t3_drain");
    repeat (3) tick();
    chk("t3_hs_count", 64'(lane_beat[1] - b0), 64'd4);

    // Round-robin arbiter in the loop
    bus.lane_valid = 4'b1111;
    cv = '{-1, -1, -1, -1};
    push_burst(0, cv, -1, 1'b1);
    push_burst(1, cv, -1, 1'b1);
    push_burst(2, cv, -1, 1'b1);
    push_burst(3, cv, -1, 1'b1);
    push_burst(0, cv, -1, 1'b1);
    gexp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    arb_req = 4'b1111;
    arb_en  = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && n < 5; i++) begin
      tick();
      if (bus.grant != 4'b0000) begin
        gcyc[n]  = cyc;
        glane[n] = bus.grant;
        n++;
        if (n == 5) arb_req = 4'b0000;
      end
    end
    chk("t4_grant_count", 64'(n), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < n) chk("t4_grant_order", 64'(glane[i]), 64'(gexp[i]));
      if (i > 0 && i < n) chk("t4_grant_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'(BL + 2));
    end
    drain("t4_drain");
    arb_en = 1'b0;

    // Reset after the second beat abandons the burst
    bus.lane_valid = 4'b1000;
    t = cyc;
    push_burst(3, cv, -1, 1'b0);
    stim_grant = 4'b1000;
    tick();
    stim_grant = 4'b0000;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_rst_ready", 64'(bus.lane_ready), 64'd0);
    chk("t5_rst_last", 64'(bus.out_last), 64'd0);
    chk("t5_rst_gate", 64'(bus.req_gate), 64'd1);
    chk("t5_left", 64'(exp_q.size()), 64'd2);
    exp_q.delete();
    exp_beat[3] -= 2;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_post_valid", 64'(bus.out_valid), 64'd0);
    t = cyc;
    cv = '{t+1, t+2, t+3, t+4};
    push_burst(3, cv, t + 5, 1'b1);
    stim_grant = 4'b1000;
    tick();
    stim_grant = 4'b0000;
    drain("t5_drain");

    // Multi-hot grant
    bus.lane_valid = 4'b0011;
    t = cyc;
`ifdef ARB_BURST_XFER_ERRCHK_EN
    stim_grant = 4'b0011;
    tick();
    stim_grant = 4'b0000;
    chk("t6_err", 64'(bus.err), 64'd1);
    chk("t6_no_burst", 64'(bus.out_valid), 64'd0);
    tick();
    chk("t6_still_idle", 64'(bus.out_valid), 64'd0);
    chk("t6_err_sticky", 64'(bus.err), 64'd1);
`else
    cv = '{t+1, t+2, t+3, t+4};
    push_burst(0, cv, t + 5, 1'b1);
    stim_grant = 4'b0011;
    tick();
    stim_grant = 4'b0000;
    chk("t6_err", 64'(bus.err), 64'd0);
    chk("t6_src", 64'(bus.out_src), 64'd0);
    drain("t6_drain");
`endif

    repeat (4) tick();
    chk("end_beat_q", 64'(exp_q.size()), 64'd0);
    chk("end_done_q", 64'(done_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
